// File: rtl/chip_out_pkg.sv
// Shared types and helpers for the chip output arbiter and its round-robin picker.
package chip_out_pkg;

  localparam int CHIP_OUT_DW      = 32;
  localparam int CHIP_OUT_NUM_SRC = 4;
  localparam int MAX_SRC          = 16;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    XFER
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... wrapping at n (not at a power of two) and return the first requester.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [3:0] ptr,
                                       input int n);
    rr_pick_t   r;
    int         j;
    logic [3:0] jj;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      if (k < n && !r.found) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        jj = 4'(j);
        if (req[jj]) begin
          r.found = 1'b1;
          r.idx   = jj;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, modulo N.
module rr_arbiter
  import chip_out_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_SRC'(req), 4'(ptr), N);
    found = pick.found;
    idx   = PW'(pick.idx);
  end

endmodule

// File: rtl/chip_out_arb.sv
// Packet-atomic round-robin arbiter sharing the chip output stream between NUM_SRC producers,
// with an optional one-beat source-ID header ahead of each packet.
module chip_out_arb
  import chip_out_pkg::*;
#(
  parameter int NUM_SRC = CHIP_OUT_NUM_SRC,
  parameter int DW      = CHIP_OUT_DW,
  parameter int ID_HDR  = 1,
  parameter int IDW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_vld,
  input  logic [NUM_SRC-1:0]    src_lst,
  input  logic [NUM_SRC*DW-1:0] src_dat,
  output logic [NUM_SRC-1:0]    src_rdy,
  output logic                  chip_out_vld,
  output logic                  chip_out_lst,
  output logic [DW-1:0]         chip_out_dat,
  input  logic                  chip_out_rdy,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [15:0]           pkt_cnt
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t         state, state_d;
  logic [IDW-1:0] grant_d;
  logic [IDW-1:0] rr_ptr, rr_ptr_d;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           pkt_done;
  logic [SW-1:0]  g;
  logic [DW-1:0]  dat_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign dat_arr[i] = src_dat[i*DW +: DW];
  end

  assign g = grant_id[SW-1:0];

  rr_arbiter #(
    .N  (NUM_SRC),
    .PW (IDW)
  ) u_rr (
    .req   (src_vld),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_d;
      grant_id <= grant_d;
      rr_ptr   <= rr_ptr_d;
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant_id;
    rr_ptr_d     = rr_ptr;
    pkt_done     = 1'b0;
    chip_out_vld = 1'b0;
    chip_out_lst = 1'b0;
    chip_out_dat = '0;
    src_rdy      = '0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = (ID_HDR != 0) ? HDR : XFER;
        end
      end
      HDR: begin
        chip_out_vld = 1'b1;
        chip_out_dat = DW'(grant_id);
        if (chip_out_rdy) state_d = XFER;
      end
      XFER: begin
        // Grant stays locked through bubbles; only the last-beat handshake releases it.
        chip_out_vld = src_vld[g];
        chip_out_lst = src_lst[g];
        chip_out_dat = dat_arr[g];
        src_rdy[g]   = chip_out_rdy;
        if (src_vld[g] && chip_out_rdy && src_lst[g]) begin
          pkt_done = 1'b1;
          rr_ptr_d = (int'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset acts as a flush: nothing may handshake while it is asserted.
    if (rst) begin
      chip_out_vld = 1'b0;
      chip_out_lst = 1'b0;
      chip_out_dat = '0;
      src_rdy      = '0;
      busy         = 1'b0;
      pkt_done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_chip_out_arb.sv
// Directed scoreboard bench for chip_out_arb: one instance with ID headers, one without.
module tb_chip_out_arb;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int IDW = 4;

  typedef struct {
    logic [DW-1:0] dat;
    logic          lst;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b, sel;
  logic [NS-1:0]     src_vld, src_lst, hold;
  logic [NS*DW-1:0]  src_dat;
  logic              chip_out_rdy;

  logic [NS-1:0]  a_src_rdy, b_src_rdy, o_src_rdy;
  logic           a_vld, b_vld, o_vld, a_lst, b_lst, o_lst, a_busy, b_busy, o_busy;
  logic [DW-1:0]  a_dat, b_dat, o_dat;
  logic [IDW-1:0] a_grant, b_grant, o_grant;
  logic [15:0]    a_cnt, b_cnt, o_cnt;

  chip_out_arb #(.NUM_SRC(NS), .DW(DW), .ID_HDR(1), .IDW(IDW)) dut_a (
    .clk(clk), .rst(rst_a), .src_vld(src_vld), .src_lst(src_lst), .src_dat(src_dat),
    .src_rdy(a_src_rdy), .chip_out_vld(a_vld), .chip_out_lst(a_lst), .chip_out_dat(a_dat),
    .chip_out_rdy(chip_out_rdy), .grant_id(a_grant), .busy(a_busy), .pkt_cnt(a_cnt)
  );

  chip_out_arb #(.NUM_SRC(NS), .DW(DW), .ID_HDR(0), .IDW(IDW)) dut_b (
    .clk(clk), .rst(rst_b), .src_vld(src_vld), .src_lst(src_lst), .src_dat(src_dat),
    .src_rdy(b_src_rdy), .chip_out_vld(b_vld), .chip_out_lst(b_lst), .chip_out_dat(b_dat),
    .chip_out_rdy(chip_out_rdy), .grant_id(b_grant), .busy(b_busy), .pkt_cnt(b_cnt)
  );

  assign o_src_rdy = sel ? b_src_rdy : a_src_rdy;
  assign o_vld     = sel ? b_vld     : a_vld;
  assign o_lst     = sel ? b_lst     : a_lst;
  assign o_dat     = sel ? b_dat     : a_dat;
  assign o_busy    = sel ? b_busy    : a_busy;
  assign o_grant   = sel ? b_grant   : a_grant;
  assign o_cnt     = sel ? b_cnt     : a_cnt;

  beat_t srcq [NS][$];
  beat_t expq [$];
  int    checks   = 0;
  int    failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveSources();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0) begin
        src_vld[i]            = !hold[i];
        src_lst[i]            = srcq[i][0].lst;
        src_dat[i*DW +: DW]   = srcq[i][0].dat;
      end else begin
        src_vld[i]            = 1'b0;
        src_lst[i]            = 1'b0;
        src_dat[i*DW +: DW]   = '0;
      end
    end
  endtask

  // Queue a len-beat packet on source src; optionally push its expected output (header first).
  task automatic applyStimulus(input int src, input int len, input logic [31:0] base,
                               input bit hdr, input bit expect_it);
    beat_t b;
    if (expect_it && hdr) begin
      b.dat = DW'(src);
      b.lst = 1'b0;
      expq.push_back(b);
    end
    for (int k = 0; k < len; k++) begin
      b.dat = base + 32'(k);
      b.lst = (k == len - 1);
      srcq[src].push_back(b);
      if (expect_it) expq.push_back(b);
    end
    driveSources();
  endtask

  task automatic tick();
    logic [NS-1:0] fired;
    beat_t         e;
    @(negedge clk);
    fired = src_vld & o_src_rdy;
    if (o_vld && chip_out_rdy) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL unexpected_beat observed=0x%0h expected=none", o_dat);
      end else begin
        e = expq.pop_front();
        checkOutput("beat_dat", o_dat, e.dat);
        checkOutput("beat_lst", 32'(o_lst), 32'(e.lst));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (fired[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    driveSources();
  endtask

  task automatic drain(input int maxc, input string tag);
    int n;
    n = 0;
    while ((expq.size() > 0 || o_busy) && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    assert (expq.size() == 0 && !o_busy)
    else begin
      failures++;
      $error("[TB] FAIL %s_drain observed_pending=%0d expected_pending=0", tag, expq.size());
    end
  endtask

  initial begin
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; chip_out_rdy = 1'b0;
    hold = '0; src_vld = '0; src_lst = '0; src_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_vld",   32'(o_vld), 0);
    checkOutput("rst_busy",  32'(o_busy), 0);
    checkOutput("rst_rdy",   32'(o_src_rdy), 0);
    checkOutput("rst_dat",   o_dat, 0);
    checkOutput("rst_grant", 32'(o_grant), 0);
    checkOutput("rst_cnt",   32'(o_cnt), 0);
    rst_a = 1'b0;
    chip_out_rdy = 1'b1;

    $display("[TB] single 3-beat packet from source 2");
    applyStimulus(2, 3, 32'hA0, 1, 1);
    #1;
    checkOutput("t1_idle_vld",  32'(o_vld), 0);
    checkOutput("t1_idle_busy", 32'(o_busy), 0);
    drain(40, "t1");
    checkOutput("t1_grant", 32'(o_grant), 2);
    checkOutput("t1_cnt",   32'(o_cnt), 1);

    $display("[TB] all sources requesting, round-robin order");
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    #1;
    checkOutput("t2_cnt_rst", 32'(o_cnt), 0);
    applyStimulus(0, 2, 32'h100, 1, 1);
    applyStimulus(1, 2, 32'h110, 1, 1);
    applyStimulus(2, 2, 32'h120, 1, 1);
    applyStimulus(3, 2, 32'h130, 1, 1);
    applyStimulus(0, 2, 32'h140, 1, 1);
    drain(100, "t2");
    checkOutput("t2_cnt",   32'(o_cnt), 5);
    checkOutput("t2_grant", 32'(o_grant), 0);

    $display("[TB] stalls and bubbles while source 3 waits");
    applyStimulus(1, 4, 32'h200, 1, 1);
    tick();
    applyStimulus(3, 2, 32'h300, 1, 1);
    tick();
    tick();
    chip_out_rdy = 1'b0;
    #1;
    checkOutput("t3_stall_vld",   32'(o_vld), 1);
    checkOutput("t3_stall_dat",   o_dat, 32'h201);
    checkOutput("t3_stall_rdy",   32'(o_src_rdy), 0);
    checkOutput("t3_stall_grant", 32'(o_grant), 1);
    tick();
    hold[1] = 1'b1;
    driveSources();
    #1;
    checkOutput("t3_bubble_vld",  32'(o_vld), 0);
    checkOutput("t3_bubble_busy", 32'(o_busy), 1);
    checkOutput("t3_bubble_rdy",  32'(o_src_rdy), 0);
    tick();
    chip_out_rdy = 1'b1;
    #1;
    checkOutput("t3_bubble2_vld",   32'(o_vld), 0);
    checkOutput("t3_bubble2_rdy",   32'(o_src_rdy), 32'h2);
    checkOutput("t3_bubble2_grant", 32'(o_grant), 1);
    tick();
    hold[1] = 1'b0;
    driveSources();
    #1;
    checkOutput("t3_resume_dat", o_dat, 32'h201);
    drain(60, "t3");
    checkOutput("t3_cnt",   32'(o_cnt), 7);
    checkOutput("t3_grant", 32'(o_grant), 3);

    $display("[TB] no-header instance, pointer wrap");
    sel = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    applyStimulus(3, 1, 32'h400, 0, 1);
    #1;
    checkOutput("t4_idle_vld", 32'(o_vld), 0);
    tick();
    #1;
    checkOutput("t4_first_vld",   32'(o_vld), 1);
    checkOutput("t4_first_dat",   o_dat, 32'h400);
    checkOutput("t4_first_lst",   32'(o_lst), 1);
    checkOutput("t4_first_grant", 32'(o_grant), 3);
    tick();
    applyStimulus(0, 2, 32'h420, 0, 1);
    applyStimulus(1, 1, 32'h410, 0, 1);
    #1;
    checkOutput("t4_wrap_idle_vld", 32'(o_vld), 0);
    tick();
    #1;
    checkOutput("t4_wrap_vld",   32'(o_vld), 1);
    checkOutput("t4_wrap_dat",   o_dat, 32'h420);
    checkOutput("t4_wrap_grant", 32'(o_grant), 0);
    drain(40, "t4");
    checkOutput("t4_cnt", 32'(o_cnt), 3);

    $display("[TB] reset in the middle of a packet");
    sel = 1'b0; rst_b = 1'b1;
    tick();
    rst_a = 1'b0;
    applyStimulus(0, 1, 32'h500, 1, 1);
    drain(20, "t5a");
    applyStimulus(2, 4, 32'h510, 1, 0);
    begin
      beat_t b;
      b.dat = 32'd2;   b.lst = 1'b0; expq.push_back(b);
      b.dat = 32'h510; b.lst = 1'b0; expq.push_back(b);
    end
    tick();
    tick();
    tick();
    #1;
    checkOutput("t5_beat2_dat", o_dat, 32'h511);
    rst_a = 1'b1;
    #1;
    checkOutput("t5_inrst_vld",  32'(o_vld), 0);
    checkOutput("t5_inrst_busy", 32'(o_busy), 0);
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    driveSources();
    #1;
    checkOutput("t5_post_vld",   32'(o_vld), 0);
    checkOutput("t5_post_busy",  32'(o_busy), 0);
    checkOutput("t5_post_cnt",   32'(o_cnt), 0);
    checkOutput("t5_post_grant", 32'(o_grant), 0);
    checkOutput("t5_pending",    32'(expq.size()), 0);
    applyStimulus(0, 1, 32'h520, 1, 1);
    applyStimulus(1, 1, 32'h530, 1, 1);
    drain(30, "t5b");
    checkOutput("t5_cnt",   32'(o_cnt), 2);
    checkOutput("t5_grant", 32'(o_grant), 1);

    $display("[TB] packet counter wrap");
    force dut_a.pkt_cnt = 16'hFFFF;
    #1;
    release dut_a.pkt_cnt;
    #1;
    checkOutput("t6_cnt_max", 32'(o_cnt), 32'hFFFF);
    applyStimulus(2, 1, 32'h600, 1, 1);
    drain(20, "t6");
    checkOutput("t6_cnt_wrap", 32'(o_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
